// File: rtl/i2c_slave_responder_if.sv
// Bus-side signal bundle of the I2C responder: line levels, open-drain enable,
// read-data source handshake and received-data/status pulses.
interface i2c_slave_responder_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe_o;
    logic [7:0] tx_data_i;
    logic       tx_req_o;
    logic [7:0] data_slave_read;
    logic       data_slave_read_valid;
    logic       start;
    logic       stop;
    logic       busy_o;

    modport slave (
        input  scl_i, sda_i, tx_data_i,
        output sda_oe_o, tx_req_o, data_slave_read, data_slave_read_valid,
               start, stop, busy_o
    );

    modport master (
        output scl_i, sda_i, tx_data_i,
        input  sda_oe_o, tx_req_o, data_slave_read, data_slave_read_valid,
               start, stop, busy_o
    );
endinterface

// File: rtl/i2c_slave_responder.sv
// Single-address I2C slave: START/STOP decode, address match, byte receive with
// ACK and byte transmit from tx_data_i. SDA is driven only through sda_oe_o.
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h3A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  i2c_core_clk_i,
    input  logic                  reset_i,
    i2c_slave_responder_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic       scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       rw_q, rw_d;
    logic       mack_q, mack_d;
    logic       sda_oe_q, sda_oe_d;
    logic       tx_req_q, tx_req_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       rd_valid_q, rd_valid_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;
    logic       busy_q, busy_d;

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_hist_q;
    assign scl_fall  = ~scl_s & scl_hist_q;
    // SCL must be high on both samples so an SDA change next to an SCL edge is data, not a condition
    assign start_det = scl_s & scl_hist_q & ~sda_s & sda_hist_q;
    assign stop_det  = scl_s & scl_hist_q & sda_s & ~sda_hist_q;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], bus.scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], bus.sda_i};
        scl_hist_d = scl_s;
        sda_hist_d = sda_s;
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        tx_shift_d = tx_shift_q;
        rw_d       = rw_q;
        mack_d     = mack_q;
        sda_oe_d   = sda_oe_q;
        tx_req_d   = 1'b0;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        start_d    = start_det;
        stop_d     = stop_det;
        busy_d     = busy_q;

        case (state_q)
            IDLE: ;
            ADDR: begin
                if (scl_rise && cnt_q != 4'd8) begin
                    shift_d = {shift_q[6:0], sda_s};
                    cnt_d   = cnt_q + 4'd1;
                end else if (scl_fall && cnt_q == 4'd8) begin
                    if (shift_q[7:1] == SLAVE_ADDR) begin
                        sda_oe_d = 1'b1;
                        busy_d   = 1'b1;
                        rw_d     = shift_q[0];
                        state_d  = ADDR_ACK;
                    end else begin
                        state_d  = IGNORE;
                    end
                end
            end
            ADDR_ACK: begin
                if (scl_fall) begin
                    if (!rw_q) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = 4'd0;
                        state_d  = RX;
                    end else begin
                        tx_shift_d = bus.tx_data_i;
                        tx_req_d   = 1'b1;
                        sda_oe_d   = ~bus.tx_data_i[7];
                        cnt_d      = 4'd1;
                        state_d    = TX;
                    end
                end
            end
            RX: begin
                if (scl_rise && cnt_q != 4'd8) begin
                    shift_d = {shift_q[6:0], sda_s};
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        rd_data_d  = {shift_q[6:0], sda_s};
                        rd_valid_d = 1'b1;
                    end
                end else if (scl_fall && cnt_q == 4'd8) begin
                    sda_oe_d = 1'b1;
                    state_d  = RX_ACK;
                end
            end
            RX_ACK: begin
                if (scl_fall) begin
                    sda_oe_d = 1'b0;
                    cnt_d    = 4'd0;
                    state_d  = RX;
                end
            end
            TX: begin
                // cnt_q counts bits already placed on the line; bit7 went out at the latch
                if (scl_fall) begin
                    if (cnt_q == 4'd8) begin
                        sda_oe_d = 1'b0;
                        state_d  = TX_ACK;
                    end else begin
                        sda_oe_d   = ~tx_shift_q[6];
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        cnt_d      = cnt_q + 4'd1;
                    end
                end
            end
            TX_ACK: begin
                if (scl_rise) begin
                    mack_d = sda_s;
                end else if (scl_fall) begin
                    if (!mack_q) begin
                        tx_shift_d = bus.tx_data_i;
                        tx_req_d   = 1'b1;
                        sda_oe_d   = ~bus.tx_data_i[7];
                        cnt_d      = 4'd1;
                        state_d    = TX;
                    end else begin
                        state_d    = IGNORE;
                    end
                end
            end
            IGNORE: ;
            default: state_d = IDLE;
        endcase

        if (stop_det) begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            state_d  = IDLE;
        end
        if (start_det) begin
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            state_d  = ADDR;
        end
    end

    always_ff @(posedge i2c_core_clk_i or posedge reset_i) begin
        if (reset_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            shift_q    <= 8'h00;
            tx_shift_q <= 8'h00;
            rw_q       <= 1'b0;
            mack_q     <= 1'b1;
            sda_oe_q   <= 1'b0;
            tx_req_q   <= 1'b0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tx_shift_q <= tx_shift_d;
            rw_q       <= rw_d;
            mack_q     <= mack_d;
            sda_oe_q   <= sda_oe_d;
            tx_req_q   <= tx_req_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.sda_oe_o              = sda_oe_q;
    assign bus.tx_req_o              = tx_req_q;
    assign bus.data_slave_read       = rd_data_q;
    assign bus.data_slave_read_valid = rd_valid_q;
    assign bus.start                 = start_q;
    assign bus.stop                  = stop_q;
    assign bus.busy_o                = busy_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench acting as the I2C master on an open-drain bus; transactions from a table
// and from random draws are checked against a transaction-level expectation model.
module tb_i2c_slave_responder;
    localparam int Q = 8;  // clocks per SCL quarter phase

    typedef struct {
        logic [6:0]      addr;
        logic            rw;
        int              n;
        logic [3:0][7:0] d;
        logic            exp_ack;
        int              exp_valid;
        int              exp_txreq;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    always #5 clk = ~clk;

    i2c_slave_responder_if bus();
    assign bus.scl_i = scl_m;
    assign bus.sda_i = sda_m & ~bus.sda_oe_o;

    i2c_slave_responder #(.SLAVE_ADDR(7'h3A), .SYNC_STAGES(2)) dut (
        .i2c_core_clk_i (clk),
        .reset_i        (rst),
        .bus            (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int start_cnt = 0, stop_cnt = 0, txreq_cnt = 0, busy_cyc = 0, oe_cyc = 0, oe_viol = 0;
    logic [7:0] valid_q[$];
    logic oe_prev = 1'b0;
    logic scl_prev = 1'b1;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.start) start_cnt++;
            if (bus.stop) stop_cnt++;
            if (bus.tx_req_o) txreq_cnt++;
            if (bus.busy_o) busy_cyc++;
            if (bus.sda_oe_o) oe_cyc++;
            if (bus.data_slave_read_valid) valid_q.push_back(bus.data_slave_read);
            if (bus.sda_oe_o !== oe_prev && scl_m && scl_prev) oe_viol++;
        end
        oe_prev  = bus.sda_oe_o;
        scl_prev = scl_m;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
    endtask

    task automatic qw();
        repeat (Q) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, output logic r);
        sda_m = b; qw();
        scl_m = 1'b1; qw();
        r = bus.sda_i; qw();
        scl_m = 1'b0; qw();
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; qw();
        scl_m = 1'b1; qw();
        sda_m = 1'b0; qw();
        scl_m = 1'b0; qw();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; qw();
        scl_m = 1'b1; qw();
        sda_m = 1'b1; qw();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic nack);
        logic r;
        for (int k = 7; k >= 0; k--) send_bit(b[k], r);
        send_bit(1'b1, nack);
    endtask

    task automatic run_txn(input logic [6:0] addr, input logic rw, input int n,
                           input logic [3:0][7:0] d, input bit do_stop,
                           output logic acked, output logic [3:0] dacks,
                           output logic [3:0][7:0] rd);
        logic nk, b;
        dacks = '0;
        rd    = '0;
        if (rw) bus.tx_data_i = d[0];
        i2c_start();
        write_byte({addr, rw}, nk);
        acked = ~nk;
        if (!rw) begin
            for (int i = 0; i < n; i++) begin
                write_byte(d[i], nk);
                dacks[i] = ~nk;
            end
        end else if (acked) begin
            for (int i = 0; i < n; i++) begin
                for (int k = 7; k >= 0; k--) begin
                    send_bit(1'b1, b);
                    rd[i][k] = b;
                end
                if (i + 1 < n) bus.tx_data_i = d[i+1];
                send_bit(i == n - 1, nk);  // ACK all but the last byte
            end
        end
        if (do_stop) i2c_stop();
    endtask

    // Expected outcome from the protocol rules: only the exact address is answered,
    // every write byte is then ACKed and reported, every read byte is requested once.
    function automatic vec_t model(input vec_t v);
        vec_t e = v;
        e.exp_ack   = (v.addr == 7'h3A);
        e.exp_valid = (e.exp_ack && !v.rw) ? v.n : 0;
        e.exp_txreq = (e.exp_ack && v.rw) ? v.n : 0;
        return e;
    endfunction

    task automatic apply(input string tag, input vec_t v);
        int s0, p0, t0, b0, o0, q0;
        logic acked;
        logic [3:0] dacks;
        logic [3:0][7:0] rd;
        s0 = start_cnt; p0 = stop_cnt; t0 = txreq_cnt; b0 = busy_cyc; o0 = oe_cyc; q0 = valid_q.size();
        run_txn(v.addr, v.rw, v.n, v.d, 1'b1, acked, dacks, rd);
        chk($sformatf("%s addr_ack", tag), acked, v.exp_ack);
        chk($sformatf("%s valid_pulses", tag), valid_q.size() - q0, v.exp_valid);
        chk($sformatf("%s tx_req_pulses", tag), txreq_cnt - t0, v.exp_txreq);
        chk($sformatf("%s start_pulses", tag), start_cnt - s0, 1);
        chk($sformatf("%s stop_pulses", tag), stop_cnt - p0, 1);
        chk($sformatf("%s busy_after_stop", tag), bus.busy_o, 0);
        chk($sformatf("%s busy_seen", tag), (busy_cyc - b0) > 0, v.exp_ack);
        if (!v.exp_ack) chk($sformatf("%s sda_never_driven", tag), oe_cyc - o0, 0);
        for (int i = 0; i < v.n; i++) begin
            if (!v.rw) begin
                chk($sformatf("%s byte%0d_ack", tag, i), dacks[i], v.exp_ack);
                if (v.exp_ack && valid_q.size() > q0 + i)
                    chk($sformatf("%s rx_byte%0d", tag, i), valid_q[q0+i], v.d[i]);
            end else if (v.exp_ack) begin
                chk($sformatf("%s tx_byte%0d", tag, i), rd[i], v.d[i]);
            end
        end
    endtask

    initial begin
        vec_t tbl[4];
        vec_t v;
        logic acked, nk, r;
        logic [3:0] dacks;
        logic [3:0][7:0] rd;
        int s0, p0, q0, t0;

        tbl[0] = '{7'h3A, 1'b0, 2, {8'h00, 8'h00, 8'h0F, 8'hA5}, 1'b1, 2, 0};
        tbl[1] = '{7'h3B, 1'b0, 1, {8'h00, 8'h00, 8'h00, 8'hFF}, 1'b0, 0, 0};
        tbl[2] = '{7'h3A, 1'b1, 2, {8'h00, 8'h00, 8'h81, 8'h5C}, 1'b1, 0, 2};
        tbl[3] = '{7'h00, 1'b0, 1, {8'h00, 8'h00, 8'h00, 8'h55}, 1'b0, 0, 0};

        bus.tx_data_i = 8'h00;
        repeat (4) @(negedge clk);
        chk("reset sda_oe_o", bus.sda_oe_o, 0);
        chk("reset tx_req_o", bus.tx_req_o, 0);
        chk("reset data_slave_read", bus.data_slave_read, 8'h00);
        chk("reset valid", bus.data_slave_read_valid, 0);
        chk("reset start/stop/busy", {bus.start, bus.stop, bus.busy_o}, 3'b000);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 4; i++) apply($sformatf("tbl%0d", i), tbl[i]);

        // write, repeated START, read back
        s0 = start_cnt; p0 = stop_cnt; q0 = valid_q.size(); t0 = txreq_cnt;
        run_txn(7'h3A, 1'b0, 1, {24'h0, 8'h12}, 1'b0, acked, dacks, rd);
        chk("rs write addr_ack", acked, 1);
        chk("rs write data_ack", dacks[0], 1);
        run_txn(7'h3A, 1'b1, 1, {24'h0, 8'hC3}, 1'b1, acked, dacks, rd);
        chk("rs read addr_ack", acked, 1);
        chk("rs read byte", rd[0], 8'hC3);
        chk("rs start_pulses", start_cnt - s0, 2);
        chk("rs stop_pulses", stop_cnt - p0, 1);
        chk("rs tx_req_pulses", txreq_cnt - t0, 1);
        chk("rs valid_pulses", valid_q.size() - q0, 1);
        if (valid_q.size() > q0) chk("rs rx_byte", valid_q[q0], 8'h12);

        // STOP after 4 bits of a write byte
        q0 = valid_q.size(); p0 = stop_cnt;
        i2c_start();
        write_byte({7'h3A, 1'b0}, nk);
        chk("partial addr_ack", nk, 0);
        send_bit(1'b1, r); send_bit(1'b0, r); send_bit(1'b1, r); send_bit(1'b1, r);
        i2c_stop();
        chk("partial valid_pulses", valid_q.size() - q0, 0);
        chk("partial stop_pulses", stop_cnt - p0, 1);
        chk("partial busy_o", bus.busy_o, 0);
        apply("after_partial", '{7'h3A, 1'b0, 1, {24'h0, 8'hC7}, 1'b1, 1, 0});

        // reset while the slave drives a 0 data bit
        bus.tx_data_i = 8'h00;
        i2c_start();
        write_byte({7'h3A, 1'b1}, nk);
        chk("rst addr_ack", nk, 0);
        sda_m = 1'b1; qw();
        scl_m = 1'b1; qw();
        chk("rst driving bit7", bus.sda_oe_o, 1);
        #3 rst = 1'b1;
        #1 chk("rst sda released", bus.sda_oe_o, 0);
        chk("rst outputs", {bus.tx_req_o, bus.data_slave_read, bus.data_slave_read_valid,
                            bus.start, bus.stop, bus.busy_o}, 13'h0);
        @(negedge clk);
        sda_m = 1'b1; scl_m = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        apply("after_reset", '{7'h3A, 1'b0, 1, {24'h0, 8'h3C}, 1'b1, 1, 0});

        for (int i = 0; i < 8; i++) begin
            v.addr = ($urandom_range(0, 1) == 1) ? 7'h3A : 7'($urandom);
            v.rw   = 1'($urandom_range(0, 1));
            v.n    = $urandom_range(1, 3);
            v.d    = $urandom;
            apply($sformatf("rnd%0d", i), model(v));
        end

        chk("sda_oe stable while scl high", oe_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
